// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, host, SRAM and byte-output signals of mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12
) ();
  // PicoRV32 native memory port
  logic                  cpu_valid;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [3:0]            cpu_wstrb;
  logic                  cpu_ready;
  logic [31:0]           cpu_rdata;
  // Host (USB register block) port
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [31:0]           host_wdata;
  logic                  host_ack;
  logic [31:0]           host_rdata;
  // SRAM macro port
  logic                  sram_en;
  logic [3:0]            sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;
  // Byte-output MMIO register
  logic [7:0]            out_byte;
  logic                  out_byte_en;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    input  host_req, host_we, host_addr, host_wdata,
    input  sram_rdata,
    output cpu_ready, cpu_rdata, host_ack, host_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    output out_byte, out_byte_en
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
    output host_req, host_we, host_addr, host_wdata,
    output sram_rdata,
    input  cpu_ready, cpu_rdata, host_ack, host_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    input  out_byte, out_byte_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port firmware SRAM between the PicoRV32 and
// the host port, and decodes the CPU byte-output MMIO write.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise the CPU
// always wins ties.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_ADDR  = 32'h1000_0000
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ACC, CAP, RESP, MMIO} state_t;
  typedef enum logic {GNT_CPU, GNT_HOST} owner_t;

  state_t state;
  owner_t grant;
  logic   grant_write;
`ifdef MEM_ARB_RR_EN
  owner_t last_grant;
`endif

  logic cpu_in_range;
  logic mmio_write;
  logic host_turn;
  logic pick_host;

  // Request decode and tie-break for the IDLE sample.
  always_comb begin
    cpu_in_range = (bus.cpu_addr[31:ADDR_WIDTH+2] == '0);
    mmio_write   = (bus.cpu_addr == MMIO_ADDR) && (bus.cpu_wstrb != 4'b0000);
`ifdef MEM_ARB_RR_EN
    host_turn    = (last_grant == GNT_CPU);
`else
    host_turn    = 1'b0;
`endif
    pick_host    = bus.host_req && (!bus.cpu_valid || host_turn);
  end

  // Access sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      grant           <= GNT_CPU;
      grant_write     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant      <= GNT_HOST;
`endif
      bus.cpu_ready   <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.host_ack    <= 1'b0;
      bus.host_rdata  <= '0;
      bus.sram_en     <= 1'b0;
      bus.sram_we     <= '0;
      bus.sram_addr   <= '0;
      bus.sram_wdata  <= '0;
      bus.out_byte    <= '0;
      bus.out_byte_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Out-of-range CPU requests (MMIO included) bypass arbitration.
          if (bus.cpu_valid && !cpu_in_range) begin
            state         <= MMIO;
            bus.cpu_ready <= 1'b1;
            bus.cpu_rdata <= '0;
            if (mmio_write) begin
              bus.out_byte    <= bus.cpu_wdata[7:0];
              bus.out_byte_en <= 1'b1;
            end
          end else if (pick_host) begin
            state          <= ACC;
            grant          <= GNT_HOST;
            grant_write    <= bus.host_we;
`ifdef MEM_ARB_RR_EN
            last_grant     <= GNT_HOST;
`endif
            bus.sram_en    <= 1'b1;
            bus.sram_we    <= {4{bus.host_we}};
            bus.sram_addr  <= bus.host_addr;
            bus.sram_wdata <= bus.host_wdata;
          end else if (bus.cpu_valid) begin
            state          <= ACC;
            grant          <= GNT_CPU;
            grant_write    <= (bus.cpu_wstrb != 4'b0000);
`ifdef MEM_ARB_RR_EN
            last_grant     <= GNT_CPU;
`endif
            bus.sram_en    <= 1'b1;
            bus.sram_we    <= bus.cpu_wstrb;
            bus.sram_addr  <= bus.cpu_addr[ADDR_WIDTH+1:2];
            bus.sram_wdata <= bus.cpu_wdata;
          end
        end
        ACC: begin
          state       <= CAP;
          bus.sram_en <= 1'b0;
          bus.sram_we <= '0;
        end
        CAP: begin
          state <= RESP;
          if (grant == GNT_HOST) begin
            bus.host_ack   <= 1'b1;
            bus.host_rdata <= grant_write ? '0 : bus.sram_rdata;
          end else begin
            bus.cpu_ready  <= 1'b1;
            bus.cpu_rdata  <= grant_write ? '0 : bus.sram_rdata;
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.cpu_ready <= 1'b0;
          bus.host_ack  <= 1'b0;
        end
        MMIO: begin
          state           <= IDLE;
          bus.cpu_ready   <= 1'b0;
          bus.out_byte_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected responses computed
// from a word-array model; a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int          AW   = 12;
  localparam logic [31:0] MMIO = 32'h1000_0000;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          issue;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic [31:0]   wdata;
    int            cyc;
  } sram_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .MMIO_ADDR(MMIO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM device: synchronous read, byte-enable write
  logic [31:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.sram_we[b]) sram[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
      bus.sram_rdata <= sram[bus.sram_addr];
    end
  end

  // Reference memory and scoreboard state
  logic [31:0] ref_mem [0:(1<<AW)-1];
  resp_t       cpu_q[$];
  resp_t       host_q[$];
  sram_t       sram_q[$];
  logic [7:0]  ob_q[$];
  bit          sram_chk = 1'b1;
  int          exp_sram_cnt = 0;
  int          sram_en_cnt  = 0;
  int          host_ack_cnt = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic void fail_now(string nm, string msg);
    n_checks++;
    $display("FAIL %s: %s", nm, msg);
  endfunction

  // CPU rule model: in-range word -> SRAM, everything else completes with 0
  function automatic void cpu_expect(logic [31:0] addr, logic [31:0] wd, logic [3:0] ws, bit timed);
    resp_t       r;
    sram_t       s;
    logic [31:0] word;
    word    = addr >> 2;
    r.issue = cyc;
    if (word < (1 << AW)) begin
      r.rdata = (ws == 4'b0000) ? ref_mem[word] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (ws[b]) ref_mem[word][8*b +: 8] = wd[8*b +: 8];
      r.lat = timed ? 3 : -1;
      exp_sram_cnt++;
      if (timed) begin
        s.addr = word[AW-1:0]; s.we = ws; s.wdata = wd; s.cyc = cyc + 1;
        sram_q.push_back(s);
      end
    end else begin
      r.rdata = 32'h0;
      r.lat   = timed ? 1 : -1;
      if (addr == MMIO && ws != 4'b0000) ob_q.push_back(wd[7:0]);
    end
    cpu_q.push_back(r);
  endfunction

  function automatic void host_expect(logic [AW-1:0] w, logic we, logic [31:0] wd, bit timed);
    resp_t r;
    sram_t s;
    r.issue = cyc;
    r.rdata = we ? 32'h0 : ref_mem[w];
    if (we) ref_mem[w] = wd;
    r.lat = timed ? 3 : -1;
    exp_sram_cnt++;
    if (timed) begin
      s.addr = w; s.we = {4{we}}; s.wdata = wd; s.cyc = cyc + 1;
      sram_q.push_back(s);
    end
    host_q.push_back(r);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response
  always @(negedge clk) begin
    resp_t r;
    sram_t s;
    logic [7:0] eb;
    if (!reset) begin
      if (bus.cpu_ready && bus.host_ack)
        fail_now("ready_ack_overlap", "cpu_ready=1 host_ack=1, required at most one high");
      if (bus.sram_en) begin
        sram_en_cnt++;
        if (sram_chk) begin
          if (sram_q.size() == 0) fail_now("sram_spurious", "sram_en=1, required 0 (no access pending)");
          else begin
            s = sram_q.pop_front();
            chk("sram_addr", 32'(bus.sram_addr), 32'(s.addr));
            chk("sram_we", 32'(bus.sram_we), 32'(s.we));
            if (s.we != 4'b0000) chk("sram_wdata", bus.sram_wdata, s.wdata);
            chk("sram_cycle", cyc, s.cyc);
          end
        end
      end
      if (bus.cpu_ready) begin
        if (cpu_q.size() == 0) fail_now("cpu_spurious", "cpu_ready=1, required 0 (no access pending)");
        else begin
          r = cpu_q.pop_front();
          chk("cpu_rdata", bus.cpu_rdata, r.rdata);
          if (r.lat >= 0) chk("cpu_latency", cyc - r.issue, r.lat);
        end
      end
      if (bus.host_ack) begin
        host_ack_cnt++;
        if (host_q.size() == 0) fail_now("host_spurious", "host_ack=1, required 0 (no access pending)");
        else begin
          r = host_q.pop_front();
          chk("host_rdata", bus.host_rdata, r.rdata);
          if (r.lat >= 0) chk("host_latency", cyc - r.issue, r.lat);
        end
      end
      if (bus.out_byte_en) begin
        if (ob_q.size() == 0) fail_now("ob_spurious", "out_byte_en=1, required 0 (no MMIO write pending)");
        else begin
          eb = ob_q.pop_front();
          chk("out_byte", 32'(bus.out_byte), 32'(eb));
          chk("ob_with_ready", 32'(bus.cpu_ready), 32'd1);
        end
      end
    end
  end

  task automatic wait_cpu(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("cpu_timeout", $sformatf("no cpu_ready within %0d cycles, required one", budget));
  endtask

  task automatic wait_host(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.host_ack) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("host_timeout", $sformatf("no host_ack within %0d cycles, required one", budget));
  endtask

  task automatic cpu_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ws, input int gap);
    bit ok;
    @(negedge clk);
    bus.cpu_valid = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wstrb = ws;
    cpu_expect(a, d, ws, 1'b1);
    wait_cpu(100, ok);
    bus.cpu_valid = 1'b0; bus.cpu_wstrb = 4'b0000;
    repeat (gap) @(posedge clk);
  endtask

  task automatic host_access(input logic [AW-1:0] w, input logic we, input logic [31:0] d, input int gap);
    bit ok;
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = w; bus.host_wdata = d;
    host_expect(w, we, d, 1'b1);
    wait_host(100, ok);
    bus.host_req = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic check_outputs_zero();
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_host_ack", 32'(bus.host_ack), 32'd0);
    chk("rst_host_rdata", bus.host_rdata, 32'd0);
    chk("rst_sram_en", 32'(bus.sram_en), 32'd0);
    chk("rst_sram_we", 32'(bus.sram_we), 32'd0);
    chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst_sram_wdata", bus.sram_wdata, 32'd0);
    chk("rst_out_byte", 32'(bus.out_byte), 32'd0);
    chk("rst_out_byte_en", 32'(bus.out_byte_en), 32'd0);
  endtask

  // CPU requests back-to-back: the next request is up on the ready cycle
  task automatic cpu_stream(input int n, input int exp_gap, input int exp_host_acks);
    int t0, last_t, hs;
    bit ok;
    @(negedge clk);
    t0 = cyc; last_t = cyc; hs = host_ack_cnt;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, d;
      logic [3:0]  ws;
      a  = 32'($urandom_range(0, 255)) << 2;
      d  = $urandom;
      ws = 4'($urandom_range(0, 15));
      bus.cpu_valid = 1'b1; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wstrb = ws;
      cpu_expect(a, d, ws, 1'b0);
      wait_cpu(400, ok);
      if (!ok) break;
      if (i == 0) chk("contend_first_cpu", cyc - t0, 3);
      else chk("cpu_grant_gap", cyc - last_t, exp_gap);
      last_t = cyc;
    end
    bus.cpu_valid = 1'b0; bus.cpu_wstrb = 4'b0000;
    chk("host_acks_during_cpu", host_ack_cnt - hs, exp_host_acks);
  endtask

  task automatic host_stream(input int n, input int exp_gap);
    int last_t;
    bit ok;
    @(negedge clk);
    last_t = cyc;
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] w;
      logic          we;
      logic [31:0]   d;
      w  = AW'($urandom_range(256, 511));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = w; bus.host_wdata = d;
      host_expect(w, we, d, 1'b0);
      wait_host(400, ok);
      if (!ok) break;
      if (i > 0) chk("host_grant_gap", cyc - last_t, exp_gap);
      last_t = cyc;
    end
    bus.host_req = 1'b0;
  endtask

  task automatic random_seq(input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned sel, kind, gap;
      logic [31:0] a, d;
      logic [3:0]  ws;
      sel  = $urandom_range(0, 9);
      kind = $urandom_range(0, 9);
      gap  = $urandom_range(1, 3);
      d    = $urandom;
      ws   = 4'($urandom_range(0, 15));
      if (kind < 7)       a = 32'($urandom_range(0, 4095)) << 2;
      else if (kind == 7) a = MMIO;
      else if (kind == 8) a = 32'h0000_4000 + (32'($urandom_range(0, 1023)) << 2);
      else                a = ($urandom | 32'h2000_0000) & 32'hFFFF_FFFC;
      if (sel < 6) cpu_access(a, d, ws, int'(gap));
      else host_access(AW'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), d, int'(gap));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] hd;
    bus.cpu_valid = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
    bus.host_req  = 1'b0; bus.host_we  = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      sram[i]    <= v;
      ref_mem[i]  = v;
    end
    sram[4]    <= 32'h1122_3344;
    ref_mem[4]  = 32'h1122_3344;

    repeat (3) @(negedge clk);
    check_outputs_zero();
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Partial CPU write then read-back, MMIO write, out-of-range, boundaries
    cpu_access(32'h0000_0010, 32'hAABB_CCDD, 4'b0101, 1);
    cpu_access(32'h0000_0010, 32'h0, 4'b0000, 1);
    cpu_access(MMIO, 32'h0000_0041, 4'b0001, 1);
    cpu_access(32'h0001_0000, 32'h0, 4'b0000, 1);
    cpu_access(MMIO, 32'h0, 4'b0000, 1);
    cpu_access(32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 1);
    cpu_access(32'h0000_3FFC, 32'hCAFE_F00D, 4'b1111, 1);
    cpu_access(32'h0000_3FFC, 32'h0, 4'b0000, 2);
    host_access(AW'(100), 1'b1, 32'h5A5A_1234, 1);
    host_access(AW'(100), 1'b0, 32'h0, 1);
    host_access(AW'(4095), 1'b0, 32'h0, 1);

    // Reset while a host write to word 5 is in ACC
    @(negedge clk);
    hd = 32'h0BAD_0005;
    bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = AW'(5); bus.host_wdata = hd;
    begin
      sram_t s;
      s.addr = AW'(5); s.we = 4'hF; s.wdata = hd; s.cyc = cyc + 1;
      sram_q.push_back(s);
      exp_sram_cnt++;
    end
    @(negedge clk);
    #2 reset = 1'b1;
    bus.host_req = 1'b0;
    #1 check_outputs_zero();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    cpu_access(32'h0000_0014, 32'h0, 4'b0000, 1);

    random_seq(60);

    // Contention from a fresh reset so the first tie is deterministic
    repeat (2) @(posedge clk);
    sram_chk = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    fork
      cpu_stream(6, RR_EN ? 8 : 4, RR_EN ? 5 : 0);
      host_stream(RR_EN ? 6 : 1, 8);
    join
    repeat (2) @(posedge clk);
    sram_chk = 1'b1;

    random_seq(30);

    repeat (6) @(posedge clk);
    chk("sram_en_count", sram_en_cnt, exp_sram_cnt);
    chk("cpu_q_left", cpu_q.size(), 0);
    chk("host_q_left", host_q.size(), 0);
    chk("sram_q_left", sram_q.size(), 0);
    chk("ob_q_left", ob_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 32-bit firmware SRAM between the PicoRV32 native memory interface and a host-side port. The host port is fed from the USB register block for firmware load and readback. The block also decodes the CPU's byte-output MMIO write. It sits between `picorv32` and the SRAM macro in `system`, and replaces the inline memory `always` block there.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: SRAM word-address bits (4096 words = 16 kB).
- `MMIO_ADDR`, default 32'h1000_0000: CPU byte address of the out_byte register.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_valid`  in  1  PicoRV32 `mem_valid`.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  write data.
- `cpu_wstrb`  in  4  byte strobes; 0 means read.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  32  read data, valid while `cpu_ready`=1.
- `host_req`  in  1  host access request; level, held until `host_ack`.
- `host_we`  in  1  1 = full-word write.
- `host_addr`  in  ADDR_WIDTH  word address.
- `host_wdata`  in  32  write data.
- `host_ack`  out  1  one-cycle completion pulse.
- `host_rdata`  out  32  read data, valid while `host_ack`=1.
- `sram_en`  out  1  SRAM access enable.
- `sram_we`  out  4  byte write enables.
- `sram_addr`  out  ADDR_WIDTH  word address.
- `sram_wdata`  out  32  write data.
- `sram_rdata`  in  32  synchronous read data, valid the cycle after `sram_en` with `sram_we`=0.
- `out_byte`  out  8  last byte written to MMIO_ADDR.
- `out_byte_en`  out  1  one-cycle strobe on each MMIO write.

## Operation
- The FSM has five states: IDLE, ACC, CAP, RESP, MMIO. All outputs are registered.
- Reset values: state IDLE; every output 0, including `out_byte`. Reset mid-access abandons the access and no ready/ack is issued.
- **IDLE:** samples both requests.
  - A CPU request with `cpu_addr[31:2]` < 2^ADDR_WIDTH and a host request are eligible for the SRAM.
  - A CPU request to MMIO_ADDR with nonzero `cpu_wstrb` goes to MMIO.
  - Any other CPU request is out of range. It goes to MMIO and completes with `cpu_rdata`=0; writes are dropped and `out_byte_en` stays 0.
- **Arbitration:** CPU-fixed priority, unless the RR option below is compiled in. MMIO and out-of-range CPU requests win immediately.
- **ACC:**
  - `sram_en`=1.
  - `sram_addr` is `cpu_addr[ADDR_WIDTH+1:2]` or `host_addr`.
  - `sram_we` is `cpu_wstrb`, or {4{host_we}} for the host.
  - `sram_wdata` comes from the winner.
- **CAP:** `sram_en`=0; `sram_rdata` is captured into the winner's rdata register. For writes the captured value is don't-care and rdata is driven 0.
- **RESP:** the winner's `cpu_ready` or `host_ack` is 1 for exactly one cycle, then the FSM returns to IDLE.
- **MMIO:**
  - `cpu_ready`=1 for one cycle.
  - On an in-range MMIO write: `out_byte` ← `cpu_wdata[7:0]` and `out_byte_en`=1 in the same cycle.
  - Then IDLE.
- Request signals are sampled only in IDLE. A requester that drops its request after grant still gets its ready/ack pulse, which it must ignore.
- The loser keeps its request asserted and is granted at the next IDLE.

## Timing
- SRAM access: request seen in IDLE at cycle 0 → ACC at cycle 1 → CAP at cycle 2 → ready/ack at cycle 3 → IDLE at cycle 4.
- MMIO and out-of-range accesses: ready at cycle 1.
- Each access has one IDLE cycle. Maximum throughput is one SRAM access per 4 cycles.
- `cpu_ready` and `host_ack` are never high in the same cycle.
- `sram_en` is high for exactly one cycle per granted SRAM access.

## Configuration
- **`MEM_ARB_RR_EN` defined:** round-robin on contention.
  - A `last_grant` flip-flop (reset value = host) records the last SRAM winner.
  - When both request in IDLE, the requester that is not `last_grant` wins. With the reset value, the CPU wins the first tie.
  - `last_grant` updates on every SRAM grant.
- **Undefined:** the CPU always wins ties, and the host waits until an IDLE cycle with `cpu_valid`=0.

## Test plan
- **Reset mid-ACC:** assert `reset` during a host write to word 5 → all outputs 0 immediately; no `host_ack`; FSM in IDLE after release.
- **CPU write then read:**
  - Write `cpu_addr`=0x10, `cpu_wstrb`=4'b0101, `cpu_wdata`=0xAABBCCDD to SRAM preloaded 0x11223344 → `sram_we`=4'b0101 at cycle 1; `cpu_ready` at cycle 3.
  - Subsequent read of the same address → `cpu_rdata`=0x11BB33DD at cycle 3.
- **MMIO write:** `cpu_addr`=0x1000_0000, `cpu_wdata`=0x41 → `cpu_ready` and `out_byte_en` high at cycle 1; `out_byte`=0x41; `sram_en` never asserted.
- **Out of range:** CPU read of 0x0001_0000 with ADDR_WIDTH=12 → `cpu_ready` at cycle 1, `cpu_rdata`=0, no SRAM access.
- **Contention without `MEM_ARB_RR_EN`:** CPU and host both continuously request → CPU granted every time; `host_ack` never asserted.
- **Contention with `MEM_ARB_RR_EN`:** CPU and host both continuously request → grants alternate CPU, host, CPU, host; each gets an ack every 8 cycles.
